// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit unsigned adder built from a chain of single-bit
// full-adder cells, with registered sum and carry-out (fixed 1-cycle latency).
//
// Optional feature (compile-time macro RIPPLE_CARRY_ADDER_OVF_EN):
//   when defined, adds a registered two's-complement overflow output 'ovf'.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset; clears all outputs
//   a      in   WIDTH  unsigned operand A
//   b      in   WIDTH  unsigned operand B
//   cin    in   1      carry-in to bit 0
//   s      out  WIDTH  registered sum, (a + b + cin) mod 2^WIDTH
//   cout   out  1      registered carry-out of bit WIDTH-1
//   ovf    out  1      registered signed overflow (only with RIPPLE_CARRY_ADDER_OVF_EN)

module ripple_carry_adder #(
  parameter int unsigned WIDTH = 4  // legal range 1..64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             c_msb;    // carry into bit WIDTH-1

  logic [WIDTH-1:0] s_q;
  logic             cout_q;

  // Full-adder chain. Each loop iteration is one cell; the running carry is
  // a single variable so the chain stays a pure ripple with no lookahead.
  always_comb begin
    logic carry;
    logic p;
    sum_d = '0;
    c_msb = 1'b0;
    carry = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i == WIDTH - 1) begin
        c_msb = carry;
      end
      p        = a[i] ^ b[i];
      sum_d[i] = p ^ carry;
      carry    = (a[i] & b[i]) | (carry & p);
    end
    cout_d = carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= '0;
      cout_q <= 1'b0;
    end else begin
      s_q    <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= cout_d ^ c_msb;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_c_msb;
  assign unused_c_msb = c_msb;
`endif

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH = 4).
// A behavioural model tracks the expected registered outputs from plain
// arithmetic; a compare process checks the DUT against it every falling edge.
// Directed vectors additionally pin literal expectations.

module tb_ripple_carry_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] s;
  logic         cout;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_vec;
  int n_err;
  bit chk_en;

  ripple_carry_adder #(
    .WIDTH(W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    .ovf  (ovf),
`endif
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: result of the previous edge's operands, cleared by reset.
  logic [W-1:0] exp_s;
  logic         exp_cout;
  logic         exp_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_s    <= '0;
      exp_cout <= 1'b0;
      exp_ovf  <= 1'b0;
    end else begin
      int total;
      int sa;
      int sb;
      int sr;
      total = int'(a) + int'(b) + int'(cin);
      exp_s    <= W'(total % (1 << W));
      exp_cout <= (total >= (1 << W));
      // Signed interpretation: overflow when the true signed sum leaves range.
      sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
      sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
      sr = sa + sb + int'(cin);
      exp_ovf <= (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Compare process: DUT vs model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_s", 64'(s), 64'(exp_s));
      check("model_cout", 64'(cout), 64'(exp_cout));
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
      check("model_ovf", 64'(ovf), 64'(exp_ovf));
`endif
    end
  end

  // Drive operands on a falling edge, then check the literal result just after
  // the capturing rising edge.
  task automatic pin(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                     input logic [W-1:0] es, input logic ec, input string name);
    @(negedge clk);
    a   = ta;
    b   = tb;
    cin = tc;
    @(posedge clk);
    #1;
    check({name, "_s"}, 64'(s), 64'(es));
    check({name, "_cout"}, 64'(cout), 64'(ec));
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    chk_en = 1'b1;
    rst_n  = 1'b0;
    a      = 4'hF;
    b      = 4'hF;
    cin    = 1'b1;

    // Reset held across 3 edges with all-ones operands.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold_s", 64'(s), 64'h0);
      check("rst_hold_cout", 64'(cout), 64'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_s", 64'(s), 64'hF);
    check("rst_release_cout", 64'(cout), 64'h1);

    // Literal pins (also keep the model honest).
    pin(4'h5, 4'h3, 1'b1, 4'h9, 1'b0, "ex_5_3_1");
    pin(4'hF, 4'h0, 1'b1, 4'h0, 1'b1, "wrap_f_0_1");
    pin(4'h8, 4'h8, 1'b0, 4'h0, 1'b1, "wrap_8_8_0");
    pin(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "ones_ones_1");
    pin(4'h0, 4'h0, 1'b1, 4'h1, 1'b0, "cin_only");
    // Back-to-back on consecutive cycles.
    pin(4'h1, 4'h1, 1'b0, 4'h2, 1'b0, "b2b_first");
    pin(4'h7, 4'h9, 1'b0, 4'h0, 1'b1, "b2b_second");

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    pin(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, "ovf_pos");
    check("ovf_pos_ovf", 64'(ovf), 64'h1);
    pin(4'hF, 4'h1, 1'b0, 4'h0, 1'b1, "ovf_none");
    check("ovf_none_ovf", 64'(ovf), 64'h0);
`endif

    // Async reset between edges while s = 0xA.
    pin(4'h5, 4'h5, 1'b0, 4'hA, 1'b0, "pre_async");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_s", 64'(s), 64'h0);
    check("async_rst_cout", 64'(cout), 64'h0);
    rst_n = 1'b1;

    // Exhaustive sweep, one operand set per clock; the compare process checks.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          a   = W'(i);
          b   = W'(j);
          cin = k[0];
        end
      end
    end
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
